// File: rtl/i2c_slave_write_byte_pkg.sv
// ----------------------------------------------------------------------------
// i2c_pkg -- shared definitions for the I2C slave byte writer.
//   I2C_BITS_PER_BYTE : data bits per byte on the bus (8)
//   I2C_CNT_W         : width of the bit counter
//   i2c_wr_state_e    : byte-writer FSM states
//   is_last_bit()     : true when the counter points at the final data bit
// ----------------------------------------------------------------------------
package i2c_pkg;

    localparam int I2C_BITS_PER_BYTE = 8;
    localparam int I2C_CNT_W         = $clog2(I2C_BITS_PER_BYTE);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOW      = 3'd1,
        ST_HIGH     = 3'd2,
        ST_ACK_LOW  = 3'd3,
        ST_ACK_HIGH = 3'd4,
        ST_DONE     = 3'd5
    } i2c_wr_state_e;

    function automatic logic is_last_bit(input logic [I2C_CNT_W-1:0] cnt);
        return cnt == I2C_CNT_W'(I2C_BITS_PER_BYTE - 1);
    endfunction

endpackage

// File: rtl/i2c_slave_write_byte_if.sv
// ----------------------------------------------------------------------------
// i2c_slave_write_byte_if -- handshake and bus signals of the byte writer.
//   byte_write_en     : master -> slave, enable for one byte
//   byte_write_i      : master -> slave, byte to send (MSB first)
//   byte_write_finish : slave -> master, one-clk end-of-byte pulse
//   byte_write_err    : slave -> master, sticky bus-mismatch flag
//   ack_o             : slave -> master, ACK seen from bus master (1 = ACK)
//   scl_i, sda_i      : bus inputs, already synchronous to clk
//   sda_o             : open-drain SDA drive (0 = pull low, 1 = release)
// Modports: slave (the byte writer), master (the controlling logic / bench).
// ----------------------------------------------------------------------------
interface i2c_slave_write_byte_if;

    logic                                  byte_write_en;
    logic [i2c_pkg::I2C_BITS_PER_BYTE-1:0] byte_write_i;
    logic                                  byte_write_finish;
    logic                                  byte_write_err;
    logic                                  ack_o;
    logic                                  scl_i;
    logic                                  sda_i;
    logic                                  sda_o;

    modport slave (
        input  byte_write_en,
        input  byte_write_i,
        input  scl_i,
        input  sda_i,
        output byte_write_finish,
        output byte_write_err,
        output ack_o,
        output sda_o
    );

    modport master (
        output byte_write_en,
        output byte_write_i,
        output scl_i,
        output sda_i,
        input  byte_write_finish,
        input  byte_write_err,
        input  ack_o,
        input  sda_o
    );

endinterface

// File: rtl/i2c_slave_write_byte_bit.sv
// ----------------------------------------------------------------------------
// i2c_slave_write_bit -- single-bit SDA driver with arbitration check.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start_i     : begin a new byte: clear lost flag, drive bit_i
//   shift_i     : (re)drive bit_i unless arbitration has been lost
//   release_i   : release SDA (drive 1); highest priority
//   check_i     : compare sda_i against our drive this clk
//   bit_i       : data bit to present
//   sda_i       : sampled bus SDA
//   sda_o       : registered open-drain drive
//   mismatch_o  : bus disagrees with our drive (valid only with check_i)
// ----------------------------------------------------------------------------
module i2c_slave_write_bit (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic shift_i,
    input  logic release_i,
    input  logic check_i,
    input  logic bit_i,
    input  logic sda_i,
    output logic sda_o,
    output logic mismatch_o
);

    logic sda_q, sda_d;
    logic lost_q, lost_d;

    assign mismatch_o = check_i & (sda_i ^ sda_q);

    always_comb begin
        sda_d  = sda_q;
        lost_d = lost_q;
        if (release_i) begin
            sda_d = 1'b1;
        end else if (start_i) begin
            lost_d = 1'b0;
            sda_d  = bit_i;
        end else begin
            // Losing arbitration releases the line at once and keeps it
            // released for every later bit of this byte.
            if (mismatch_o) begin
                lost_d = 1'b1;
                sda_d  = 1'b1;
            end
            if (shift_i) begin
                sda_d = lost_d ? 1'b1 : bit_i;
            end
        end
    end

    // Async reset releases SDA immediately, even mid-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_q  <= 1'b1;
            lost_q <= 1'b0;
        end else begin
            sda_q  <= sda_d;
            lost_q <= lost_d;
        end
    end

    assign sda_o = sda_q;

endmodule

// File: rtl/i2c_slave_write_byte.sv
// ----------------------------------------------------------------------------
// i2c_slave_write_byte -- shifts one byte out on SDA (MSB first) as an I2C
// slave transmitter, following the master's SCL.
//   clk   : system clock, all logic on posedge
//   rst_n : asynchronous active-low reset
//   bus   : i2c_slave_write_byte_if.slave (enable/byte in, finish/err/ack
//           out, scl_i/sda_i in, sda_o open-drain out)
// Optional feature: define I2C_SLAVE_WRITE_ACK_EN to add the 9th (ACK) clock,
// sampling the master's ACK into ack_o. Undefined: no ACK phase, ack_o = 0,
// finish follows the 8th SCL fall.
// The byte level owns the counter, shift register, ACK and finish; the
// per-bit drive and arbitration check live in i2c_slave_write_bit.
// ----------------------------------------------------------------------------
module i2c_slave_write_byte
    import i2c_pkg::*;
(
    input logic                   clk,
    input logic                   rst_n,
    i2c_slave_write_byte_if.slave bus
);

    // ---------------- SCL edge detect ----------------
    logic scl_last_q;
    logic rise, fall;

    assign rise = ~scl_last_q &  bus.scl_i;
    assign fall =  scl_last_q & ~bus.scl_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) scl_last_q <= 1'b1;
        else        scl_last_q <= bus.scl_i;
    end

    // ---------------- state / datapath ----------------
    i2c_wr_state_e                state_q, state_d;
    logic [I2C_BITS_PER_BYTE-1:0] shreg_q, shreg_d;
    logic [I2C_CNT_W-1:0]         cnt_q, cnt_d;
    logic                         err_q, err_d;
    logic                         finish_q, finish_d;
`ifdef I2C_SLAVE_WRITE_ACK_EN
    logic                         ack_q, ack_d;
`endif

    logic bit_start, bit_shift, bit_release, bit_check;
    logic bit_val, mismatch, sda_drv;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; dropping the enable aborts from any state.
    always_comb begin
        state_d = state_q;
        if (!bus.byte_write_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_LOW;
                ST_LOW:  if (rise) state_d = ST_HIGH;
                ST_HIGH: begin
                    if (fall) begin
`ifdef I2C_SLAVE_WRITE_ACK_EN
                        state_d = is_last_bit(cnt_q) ? ST_ACK_LOW : ST_LOW;
`else
                        state_d = is_last_bit(cnt_q) ? ST_DONE : ST_LOW;
`endif
                    end
                end
`ifdef I2C_SLAVE_WRITE_ACK_EN
                ST_ACK_LOW:  if (rise) state_d = ST_ACK_HIGH;
                ST_ACK_HIGH: if (fall) state_d = ST_DONE;
`endif
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output / datapath next-state logic
    always_comb begin
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        finish_d    = 1'b0;
        bit_start   = 1'b0;
        bit_shift   = 1'b0;
        bit_release = 1'b0;
        bit_check   = 1'b0;
`ifdef I2C_SLAVE_WRITE_ACK_EN
        ack_d       = ack_q;
`endif
        if (!bus.byte_write_en) begin
            bit_release = 1'b1;
            err_d       = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    shreg_d   = bus.byte_write_i;
                    cnt_d     = '0;
                    bit_start = 1'b1;
`ifdef I2C_SLAVE_WRITE_ACK_EN
                    ack_d     = 1'b0;
`endif
                end
                // Re-presenting shreg[7] every LOW clk keeps SDA steady,
                // including on the clk the rise is detected.
                ST_LOW: bit_shift = 1'b1;
                ST_HIGH: begin
                    bit_check = 1'b1;
                    if (mismatch) err_d = 1'b1;
                    if (fall) begin
                        if (is_last_bit(cnt_q)) begin
                            bit_release = 1'b1;
`ifndef I2C_SLAVE_WRITE_ACK_EN
                            finish_d    = 1'b1;
`endif
                        end else begin
                            // Shift and drive the next bit in the same clk.
                            shreg_d   = {shreg_q[I2C_BITS_PER_BYTE-2:0], 1'b0};
                            cnt_d     = cnt_q + I2C_CNT_W'(1);
                            bit_shift = 1'b1;
                        end
                    end
                end
`ifdef I2C_SLAVE_WRITE_ACK_EN
                ST_ACK_LOW: begin
                    bit_release = 1'b1;
                    if (rise) ack_d = ~bus.sda_i;
                end
                ST_ACK_HIGH: begin
                    bit_release = 1'b1;
                    if (fall) finish_d = 1'b1;
                end
`endif
                default: bit_release = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q  <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            finish_q <= finish_d;
        end
    end

`ifdef I2C_SLAVE_WRITE_ACK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ack_q <= 1'b0;
        else        ack_q <= ack_d;
    end
    assign bus.ack_o = ack_q;
`else
    assign bus.ack_o = 1'b0;
`endif

    // Next MSB: at load this is byte_write_i[7], after a shift the new top bit.
    assign bit_val = shreg_d[I2C_BITS_PER_BYTE-1];

    i2c_slave_write_bit u_bit (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (bit_start),
        .shift_i    (bit_shift),
        .release_i  (bit_release),
        .check_i    (bit_check),
        .bit_i      (bit_val),
        .sda_i      (bus.sda_i),
        .sda_o      (sda_drv),
        .mismatch_o (mismatch)
    );

    assign bus.sda_o             = sda_drv;
    assign bus.byte_write_err    = err_q;
    assign bus.byte_write_finish = finish_q;

endmodule

// File: tb/tb_i2c_slave_write_byte.sv
module tb_i2c_slave_write_byte;

`ifdef I2C_SLAVE_WRITE_ACK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic pull_low;
    int   checks = 0;
    int   errors = 0;

    i2c_slave_write_byte_if bus ();

    // Wired-AND bus: master/other device pulls low, otherwise our drive.
    assign bus.sda_i = bus.sda_o & ~pull_low;

    i2c_slave_write_byte dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic act, input logic req);
        checks++;
        assert (act === req) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, act, req);
        end
    endtask

    // Reference: bit i (0 = first on the wire) carries b[7-i] until some
    // device pulls low while we release; from then on we stay released.
    task automatic model_byte(input logic [7:0] b, input logic [7:0] pm,
                              output logic [7:0] es, output logic [7:0] ee);
        logic lost;
        logic err;
        lost = 1'b0;
        err  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            es[i] = lost ? 1'b1 : b[7-i];
            if (es[i] && pm[i]) begin
                lost = 1'b1;
                err  = 1'b1;
            end
            ee[i] = err;
        end
    endtask

    // Send one byte. pm[i]: bus pulled low during high of bit i.
    // mack: master ACKs. abort_after: drop enable after that bit's fall (-1 = none).
    task automatic send_byte(input logic [7:0] b, input logic [7:0] pm,
                             input logic mack, input int abort_after);
        logic [7:0] es, ee;
        logic       exp_ack;
        int         n;
        model_byte(b, pm, es, ee);
        exp_ack = ACK_EN ? mack : 1'b0;
        bus.scl_i = 1'b0;
        tick();
        tick();
        bus.byte_write_en = 1'b1;
        bus.byte_write_i  = b;
        tick();
        bus.byte_write_i  = 8'($urandom);   // must be ignored after load
        for (int i = 0; i < 8; i++) begin
            n = $urandom_range(2, 4);
            for (int k = 0; k < n; k++) begin
                chk("sda_low", bus.sda_o, es[i]);
                chk("fin_low", bus.byte_write_finish, 1'b0);
                tick();
            end
            bus.scl_i = 1'b1;
            pull_low  = pm[i];
            n = $urandom_range(2, 4);
            for (int k = 0; k < n; k++) begin
                tick();
                chk("sda_high", bus.sda_o, es[i]);
            end
            chk("err_bit", bus.byte_write_err, ee[i]);
            bus.scl_i = 1'b0;
            pull_low  = 1'b0;
            tick();
            if (i == abort_after) begin
                chk("sda_after_fall", bus.sda_o, es[i+1]);
                bus.byte_write_en = 1'b0;
                tick();
                chk("abort_sda", bus.sda_o, 1'b1);
                chk("abort_err", bus.byte_write_err, 1'b0);
                chk("abort_fin", bus.byte_write_finish, 1'b0);
                tick();
                chk("abort_fin2", bus.byte_write_finish, 1'b0);
                chk("abort_sda2", bus.sda_o, 1'b1);
                return;
            end
        end
        if (ACK_EN) begin
            chk("fin_ack_low", bus.byte_write_finish, 1'b0);
            n = $urandom_range(2, 4);
            for (int k = 0; k < n; k++) begin
                chk("sda_ack_low", bus.sda_o, 1'b1);
                tick();
            end
            bus.scl_i = 1'b1;
            pull_low  = mack;
            n = $urandom_range(2, 4);
            for (int k = 0; k < n; k++) begin
                tick();
                chk("fin_ack_high", bus.byte_write_finish, 1'b0);
            end
            bus.scl_i = 1'b0;
            pull_low  = 1'b0;
            tick();
        end
        chk("finish", bus.byte_write_finish, 1'b1);
        chk("ack", bus.ack_o, exp_ack);
        chk("err_done", bus.byte_write_err, ee[7]);
        chk("sda_done", bus.sda_o, 1'b1);
        n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) begin
            tick();
            chk("finish_once", bus.byte_write_finish, 1'b0);
            chk("sda_done_hold", bus.sda_o, 1'b1);
            chk("ack_done_hold", bus.ack_o, exp_ack);
            chk("err_done_hold", bus.byte_write_err, ee[7]);
        end
        bus.byte_write_en = 1'b0;
        tick();
        chk("err_clr", bus.byte_write_err, 1'b0);
        chk("ack_keep", bus.ack_o, exp_ack);
        chk("fin_idle", bus.byte_write_finish, 1'b0);
        bus.scl_i = 1'b1;
        tick();
    endtask

    initial begin
        logic [7:0] rb, rp;
        logic       rm;
        clk               = 1'b0;
        rst_n             = 1'b0;
        pull_low          = 1'b0;
        bus.byte_write_en = 1'b0;
        bus.byte_write_i  = 8'h00;
        bus.scl_i         = 1'b1;
        tick();
        tick();
        chk("rst_sda", bus.sda_o, 1'b1);
        chk("rst_fin", bus.byte_write_finish, 1'b0);
        chk("rst_err", bus.byte_write_err, 1'b0);
        chk("rst_ack", bus.ack_o, 1'b0);
        rst_n = 1'b1;
        tick();

        send_byte(8'hA5, 8'h00, 1'b1, -1);
        send_byte(8'h3C, 8'h00, 1'b0, -1);
        send_byte(8'hFF, 8'h04, 1'b1, -1);    // pulled low on bit 2
        send_byte(8'h8F, 8'h01, 1'b1, -1);    // lost on bit 0: zeros become released
        send_byte(8'hC3, 8'h01, 1'b1, 3);     // error then abort after bit 3
        send_byte(8'h81, 8'h00, 1'b1, -1);    // clean after abort
        send_byte(8'h5A, 8'h00, 1'b0, -1);

        for (int r = 0; r < 6; r++) begin
            rb = 8'($urandom);
            rp = ($urandom_range(0, 2) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
            rm = 1'($urandom_range(0, 1));
            send_byte(rb, rp, rm, -1);
        end

        // Reset while actively pulling SDA low mid-bit.
        bus.scl_i = 1'b0;
        tick();
        bus.byte_write_en = 1'b1;
        bus.byte_write_i  = 8'h00;
        tick();
        chk("pre_rst_sda_low", bus.sda_o, 1'b0);
        bus.scl_i = 1'b1;
        tick();
        tick();
        chk("pre_rst_sda_high", bus.sda_o, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_sda", bus.sda_o, 1'b1);
        chk("async_rst_fin", bus.byte_write_finish, 1'b0);
        chk("async_rst_err", bus.byte_write_err, 1'b0);
        chk("async_rst_ack", bus.ack_o, 1'b0);
        bus.byte_write_en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        send_byte(8'h96, 8'h00, 1'b1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
